// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq -- sequential ALU with a valid/ready request side and a
// valid/ready result side.
//
// Single-cycle ops complete one cycle after accept. Multiply (op 2) and
// divide (op 3) run through WIDTH iteration cycles in BUSY before the
// result is presented. The result is held in DONE until the consumer
// takes it.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   A, B      : operands, captured on accept
//   ALU_Sel   : operation select, captured on accept
//   in_valid  : request valid
//   in_ready  : high only in IDLE
//   ALU_Out   : registered result
//   CarryOut  : registered carry / borrow / overflow / error flag
//   equal, greater, smaller : registered unsigned compare of captured A vs B
//   out_valid : high only in DONE
//   out_ready : consumer accepts the result
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             equal,
  output logic             greater,
  output logic             smaller,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             is_div_reg;
  // Shared iteration registers: for mul hi/lo hold the running product
  // (hi = upper half, lo = multiplier being shifted out); for div hi is
  // the partial remainder and lo the dividend/quotient shift register.
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] out_reg;
  logic             carry_reg;
  logic             equal_reg;
  logic             greater_reg;
  logic             smaller_reg;

  logic accept;
  logic is_iter;
  logic last_step;

  assign accept    = in_valid && (state_reg == IDLE);
  assign is_iter   = (ALU_Sel == 4'd2) || (ALU_Sel == 4'd3);
  assign last_step = (state_reg == BUSY) && (cnt_reg == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = is_iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // ---------------------------------------------------------------------
  // Single-cycle datapath (operates on the live inputs at accept)
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res_out;
  logic             res_carry;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  // Top bit of the extended difference is the borrow, i.e. A < B.
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    res_out   = '0;
    res_carry = 1'b0;
    case (ALU_Sel)
      4'd0: begin
        res_out   = sum_ext[WIDTH-1:0];
        res_carry = sum_ext[WIDTH];
      end
      4'd1: begin
        res_out   = diff_ext[WIDTH-1:0];
        res_carry = diff_ext[WIDTH];
      end
      4'd4: begin
        res_out   = {A[WIDTH-2:0], 1'b0};
        res_carry = A[WIDTH-1];
      end
      4'd5: begin
        res_out   = {1'b0, A[WIDTH-1:1]};
        res_carry = A[0];
      end
      4'd6: begin
        res_out   = {A[WIDTH-2:0], A[WIDTH-1]};
        res_carry = A[WIDTH-1];
      end
      4'd7: begin
        res_out   = {A[0], A[WIDTH-1:1]};
        res_carry = A[0];
      end
      4'd8:  res_out = A & B;
      4'd9:  res_out = A | B;
      4'd10: res_out = A ^ B;
      4'd11: res_out = ~(A | B);
      4'd12: res_out = ~(A & B);
      4'd13: res_out = ~(A ^ B);
      4'd14: res_out = {{(WIDTH-1){1'b0}}, (A > B)};
      4'd15: res_out = {{(WIDTH-1){1'b0}}, (A == B)};
      // ops 2 and 3 are produced by the iterative path
      default: begin
        res_out   = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative step: one shift-add (mul) or restoring-divide step per cycle
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
  // Shift the {carry, hi, lo} product right by one after the add.
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};

  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, b_reg});
  // When the trial subtraction succeeds the remainder is < B, so it fits
  // in WIDTH bits and the truncated difference is exact.
  assign div_sub   = div_shift[WIDTH-1:0] - b_reg;
  assign div_hi    = div_ok ? div_sub : div_shift[WIDTH-1:0];
  // With B = 0 every trial succeeds, giving the all-ones quotient.
  assign div_lo    = {lo_reg[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign step_hi = is_div_reg ? div_hi : mul_hi;
  assign step_lo = is_div_reg ? div_lo : mul_lo;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      is_div_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      out_reg     <= '0;
      carry_reg   <= 1'b0;
      equal_reg   <= 1'b0;
      greater_reg <= 1'b0;
      smaller_reg <= 1'b0;
    end else if (accept) begin
      a_reg       <= A;
      b_reg       <= B;
      is_div_reg  <= (ALU_Sel == 4'd3);
      cnt_reg     <= '0;
      equal_reg   <= (A == B);
      greater_reg <= (A > B);
      smaller_reg <= (A < B);
      hi_reg      <= '0;
      lo_reg      <= (ALU_Sel == 4'd3) ? A : B;
      out_reg     <= res_out;
      carry_reg   <= res_carry;
    end else if (state_reg == BUSY) begin
      hi_reg  <= step_hi;
      lo_reg  <= step_lo;
      cnt_reg <= cnt_reg + 1'b1;
      if (last_step) begin
        out_reg <= step_lo;
        if (is_div_reg) begin
          carry_reg <= (b_reg == '0);
        end else begin
          // Overflow: any bit set in the upper half of the product.
          carry_reg <= |step_hi;
        end
      end
    end
  end

  assign ALU_Out  = out_reg;
  assign CarryOut = carry_reg;
  assign equal    = equal_reg;
  assign greater  = greater_reg;
  assign smaller  = smaller_reg;

endmodule
